// File: rtl/dcache_ctrl_pkg.sv
// Shared types and constants for the D-cache data-array sequencer.
package dcache_ctrl_pkg;

  localparam int PKG_ADDR_WIDTH = 10;
  localparam int PKG_DATA_WIDTH = 32;
  localparam int LINE_WORDS     = 8;
  localparam int LINE_COUNT     = 2 ** (PKG_ADDR_WIDTH - 3);

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    RUN      = 2'd1,
    RF_DRAIN = 2'd2,
    RF_WRITE = 2'd3
  } dc_state_e;

  typedef struct packed {
    logic [PKG_ADDR_WIDTH-1:0] addr;
    logic [PKG_DATA_WIDTH-1:0] data;
    logic [3:0]                ben;
  } sb_entry_t;

endpackage

// File: rtl/dcache_store_buf.sv
// Posted-store FIFO with a parallel address compare across all live entries,
// used to hold back loads that would otherwise read a stale word.
module dcache_store_buf
  import dcache_ctrl_pkg::*;
#(
  parameter int SB_DEPTH = 2
) (
  input  logic                      i_clk,
  input  logic                      i_resetn,
  input  logic                      push,
  input  sb_entry_t                 push_entry,
  input  logic                      pop,
  input  logic [PKG_ADDR_WIDTH-1:0] cmp_addr,
  output logic                      full,
  output logic                      empty,
  output logic                      last,
  output sb_entry_t                 head,
  output logic                      match
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(SB_DEPTH);
  localparam logic [PTR_W:0]   CNT_EMPTY = (PTR_W + 1)'(0);

  sb_entry_t            entry_r [SB_DEPTH];
  logic [SB_DEPTH-1:0]  valid_r;
  logic [SB_DEPTH-1:0]  next_valid_s;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W:0]       count_r;
  logic                 match_s;

  // Per-entry valid bits: a simultaneous push into the popped slot keeps it valid.
  always_comb begin
    next_valid_s = (valid_r & ~(SB_DEPTH'(pop) << rd_ptr_r)) | (SB_DEPTH'(push) << wr_ptr_r);
  end

  // Hazard compare against every live entry, independent of FIFO order.
  always_comb begin
    match_s = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      match_s = match_s | (valid_r[i] & (entry_r[i].addr == cmp_addr));
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        entry_r[i] <= '0;
      end
      valid_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        entry_r[wr_ptr_r] <= push_entry;
        wr_ptr_r          <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      valid_r <= next_valid_s;
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign full  = (count_r == CNT_FULL);
  assign empty = (count_r == CNT_EMPTY);
  assign last  = (count_r == CNT_ONE);
  assign head  = entry_r[rd_ptr_r];
  assign match = match_s;

endmodule

// File: rtl/dcache_data_ctrl.sv
// Arbiter/sequencer for the single-ported D-cache data array: serialises
// loads, buffered stores, line refills and the post-reset zero walk.
module dcache_data_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = PKG_ADDR_WIDTH,
  parameter int DATA_WIDTH    = PKG_DATA_WIDTH,
  parameter int SB_DEPTH      = 2,
  parameter int CLEAR_ON_INIT = 1
) (
  input  logic                           i_clk,
  input  logic                           i_resetn,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [ADDR_WIDTH-1:0]          ld_addr,
  output logic                           ld_rvalid,
  output logic [DATA_WIDTH-1:0]          ld_rdata,
  input  logic                           st_valid,
  output logic                           st_ready,
  input  logic [ADDR_WIDTH-1:0]          st_addr,
  input  logic [DATA_WIDTH-1:0]          st_data,
  input  logic [3:0]                     st_ben,
  input  logic                           rf_valid,
  input  logic [ADDR_WIDTH-4:0]          rf_line,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] rf_data,
  output logic                           rf_done,
  output logic                           busy,
  output logic [ADDR_WIDTH-1:0]          bram_raddr,
  output logic                           bram_re,
  output logic [ADDR_WIDTH-1:0]          bram_waddr,
  output logic                           bram_we,
  output logic                           bram_store,
  output logic                           bram_hit_write,
  output logic [3:0]                     bram_byte_ben,
  output logic [DATA_WIDTH-1:0]          bram_din,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] bram_din_all,
  input  logic [DATA_WIDTH-1:0]          bram_dout
);

  localparam int CNT_W = ADDR_WIDTH - 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam dc_state_e RESET_STATE = (CLEAR_ON_INIT != 0) ? CLEAR : RUN;

  dc_state_e             state_r;
  logic                  live_r;      // low during reset and the first cycle after it
  logic [CNT_W-1:0]      cnt_r;
  logic [ADDR_WIDTH-1:0] raddr_r;
  logic                  rvalid_r;

  logic      sb_full_s, sb_empty_s, sb_last_s, sb_match_s;
  sb_entry_t sb_head_s, push_entry_s;
  logic      in_run_s, in_drain_s, ld_ready_s, ld_accept_s, st_ready_s, push_s, pop_s;

  assign push_entry_s = '{addr: st_addr, data: st_data, ben: st_ben};

  dcache_store_buf #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .cmp_addr   (ld_addr),
    .full       (sb_full_s),
    .empty      (sb_empty_s),
    .last       (sb_last_s),
    .head       (sb_head_s),
    .match      (sb_match_s)
  );

  // Port arbitration: refill > full-buffer drain > hazard-free load > opportunistic drain.
  always_comb begin
    in_run_s    = live_r & (state_r == RUN);
    in_drain_s  = live_r & (state_r == RF_DRAIN);
    ld_ready_s  = in_run_s & ~rf_valid & ~sb_full_s & ~sb_match_s;
    ld_accept_s = ld_ready_s & ld_valid;
    pop_s       = (in_run_s & ~rf_valid & (sb_full_s | (~sb_empty_s & ~ld_accept_s)))
                | (in_drain_s & ~sb_empty_s);
    st_ready_s  = in_run_s & ~rf_valid & (~sb_full_s | pop_s);
    push_s      = st_valid & st_ready_s;
  end

  // Array control: exactly one of drain, clear or refill write owns the write side.
  always_comb begin
    ld_ready       = ld_ready_s;
    st_ready       = st_ready_s;
    busy           = live_r & (state_r != RUN);
    bram_re        = ld_accept_s;
    bram_raddr     = ld_accept_s ? ld_addr : raddr_r;
    ld_rvalid      = rvalid_r;
    ld_rdata       = rvalid_r ? bram_dout : '0;
    rf_done        = 1'b0;
    bram_we        = 1'b0;
    bram_store     = 1'b0;
    bram_hit_write = 1'b0;
    bram_waddr     = '0;
    bram_byte_ben  = 4'b0000;
    bram_din       = '0;
    bram_din_all   = '0;
    if (pop_s) begin
      bram_we       = 1'b1;
      bram_store    = 1'b1;
      bram_waddr    = sb_head_s.addr;
      bram_din      = sb_head_s.data;
      bram_byte_ben = sb_head_s.ben;
    end else if (live_r && (state_r == CLEAR)) begin
      bram_we        = 1'b1;
      bram_hit_write = 1'b1;
      bram_waddr     = {cnt_r, 3'b000};
    end else if (live_r && (state_r == RF_WRITE)) begin
      bram_we        = 1'b1;
      bram_hit_write = 1'b1;
      bram_waddr     = {rf_line, 3'b000};
      bram_din_all   = rf_data;
      rf_done        = 1'b1;
    end else begin
      bram_we = 1'b0;
    end
  end

  // Sequencer state and clear-walk counter.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_r <= RESET_STATE;
      cnt_r   <= '0;
    end else if (live_r) begin
      case (state_r)
        CLEAR: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) state_r <= RUN;
        end
        RUN: begin
          if (rf_valid) state_r <= RF_DRAIN;
        end
        RF_DRAIN: begin
          if (sb_empty_s || sb_last_s) state_r <= RF_WRITE;
        end
        RF_WRITE: begin
          state_r <= RUN;
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Read-response pipeline and output-enable after reset.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      live_r   <= 1'b0;
      rvalid_r <= 1'b0;
      raddr_r  <= '0;
    end else begin
      live_r   <= 1'b1;
      rvalid_r <= ld_accept_s;
      if (ld_accept_s) raddr_r <= ld_addr;
    end
  end

endmodule

// File: tb/tb_dcache_data_ctrl.sv
// Directed, table-driven bench for dcache_data_ctrl.
module tb_dcache_data_ctrl;

  logic          i_clk = 1'b0;
  logic          i_resetn;
  logic          ld_valid, ld_ready, ld_rvalid;
  logic [9:0]    ld_addr;
  logic [31:0]   ld_rdata;
  logic          st_valid, st_ready;
  logic [9:0]    st_addr;
  logic [31:0]   st_data;
  logic [3:0]    st_ben;
  logic          rf_valid, rf_done, busy;
  logic [6:0]    rf_line;
  logic [255:0]  rf_data;
  logic [9:0]    bram_raddr, bram_waddr;
  logic          bram_re, bram_we, bram_store, bram_hit_write;
  logic [3:0]    bram_byte_ben;
  logic [31:0]   bram_din, bram_dout;
  logic [255:0]  bram_din_all;

  int tests = 0;
  int fails = 0;

  localparam logic [255:0] RF_PATTERN = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
                                         32'h33333333, 32'h22222222, 32'h11111111, 32'h0F0F0F0F};

  dcache_data_ctrl dut (
    .i_clk(i_clk), .i_resetn(i_resetn),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_ben(st_ben),
    .rf_valid(rf_valid), .rf_line(rf_line), .rf_data(rf_data), .rf_done(rf_done),
    .busy(busy),
    .bram_raddr(bram_raddr), .bram_re(bram_re), .bram_waddr(bram_waddr), .bram_we(bram_we),
    .bram_store(bram_store), .bram_hit_write(bram_hit_write), .bram_byte_ben(bram_byte_ben),
    .bram_din(bram_din), .bram_din_all(bram_din_all), .bram_dout(bram_dout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic ld_valid; logic [9:0] ld_addr;
    logic st_valid; logic [9:0] st_addr; logic [31:0] st_data; logic [3:0] st_ben;
    logic rf_valid; logic [6:0] rf_line; logic [31:0] dout;
    logic e_ldr; logic e_str; logic e_re; logic [9:0] e_raddr;
    logic e_we; logic e_store; logic e_hw; logic [9:0] e_waddr; logic [31:0] e_din; logic [3:0] e_ben;
    logic e_rfd; logic e_busy; logic e_rv; logic [31:0] e_rd; logic e_line;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ldv, input logic [9:0] lda, input logic stv, input logic [9:0] sta,
                     input logic [31:0] std, input logic [3:0] stb, input logic rfv, input logic [6:0] rfl,
                     input logic [31:0] dout,
                     input logic eldr, input logic estr, input logic ere, input logic [9:0] eraddr,
                     input logic ewe, input logic est, input logic ehw, input logic [9:0] ewaddr,
                     input logic [31:0] edin, input logic [3:0] eben, input logic erfd, input logic ebusy,
                     input logic erv, input logic [31:0] erd, input logic eline);
    vec_t v;
    v.ld_valid = ldv; v.ld_addr = lda; v.st_valid = stv; v.st_addr = sta; v.st_data = std;
    v.st_ben = stb; v.rf_valid = rfv; v.rf_line = rfl; v.dout = dout;
    v.e_ldr = eldr; v.e_str = estr; v.e_re = ere; v.e_raddr = eraddr; v.e_we = ewe;
    v.e_store = est; v.e_hw = ehw; v.e_waddr = ewaddr; v.e_din = edin; v.e_ben = eben;
    v.e_rfd = erfd; v.e_busy = ebusy; v.e_rv = erv; v.e_rd = erd; v.e_line = eline;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    #2;
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_addr = 10'h000; st_valid = 1'b0; st_addr = 10'h000;
    st_data = 32'h0; st_ben = 4'b0000; rf_valid = 1'b0; rf_line = 7'h00; bram_dout = 32'h0;
  endtask

  function automatic logic any_output();
    return |{ld_ready, ld_rvalid, ld_rdata, st_ready, rf_done, busy, bram_raddr, bram_re,
             bram_waddr, bram_we, bram_store, bram_hit_write, bram_byte_ben, bram_din, bram_din_all};
  endfunction

  // Expects the 128-line zero walk to begin within a few cycles, then RUN.
  task automatic check_clear_walk(input string name);
    int waited = 0;
    int good = 0;
    logic [9:0] wa;
    while (!(bram_we === 1'b1 && bram_hit_write === 1'b1) && waited < 4) begin
      step();
      waited++;
    end
    for (int k = 0; k < 128; k++) begin
      wa = {k[6:0], 3'b000};
      if (bram_we === 1'b1 && bram_hit_write === 1'b1 && bram_store === 1'b0 &&
          bram_waddr === wa && bram_din_all === 256'h0 && busy === 1'b1 &&
          ld_ready === 1'b0 && st_ready === 1'b0)
        good++;
      step();
    end
    check({name, "_cycles"}, 128'(good), 128'd128);
    check({name, "_done"}, {124'h0, busy, ld_ready, st_ready, bram_we}, {124'h0, 4'b0110});
  endtask

  initial begin
    logic [127:0] act, exp;
    rf_data = RF_PATTERN;
    idle_inputs();
    i_resetn = 1'b0;

    // inputs order: ldv lda stv sta std stb rfv rfl dout | ldr str re raddr we st hw waddr din ben rfd busy rv rd line
    add(1'b0,10'h000, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'h0,        1'b1,1'b1,1'b0,10'h000, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,32'h0, 1'b0);
    add(1'b1,10'h013, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'h0,        1'b1,1'b1,1'b1,10'h013, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,32'h0, 1'b0);
    add(1'b0,10'h000, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'hDEADBEEF, 1'b1,1'b1,1'b0,10'h013, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b1,32'hDEADBEEF, 1'b0);
    add(1'b0,10'h000, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'h12345678, 1'b1,1'b1,1'b0,10'h013, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,32'h0, 1'b0);
    // store then hazarding load to the same word
    add(1'b0,10'h000, 1'b1,10'h020,32'hA5A5A5A5,4'b0011, 1'b0,7'h00, 32'h0, 1'b1,1'b1,1'b0,10'h013, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,32'h0, 1'b0);
    add(1'b1,10'h020, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'h0,        1'b0,1'b1,1'b0,10'h013, 1'b1,1'b1,1'b0,10'h020,32'hA5A5A5A5,4'b0011, 1'b0,1'b0,1'b0,32'h0, 1'b0);
    add(1'b1,10'h020, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'h0,        1'b1,1'b1,1'b1,10'h020, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,32'h0, 1'b0);
    add(1'b0,10'h000, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'hCAFEF00D, 1'b1,1'b1,1'b0,10'h020, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b1,32'hCAFEF00D, 1'b0);
    // fill the buffer alongside loads, then a full buffer forces a drain ahead of load 0x100
    add(1'b1,10'h050, 1'b1,10'h040,32'h11111111,4'b1111, 1'b0,7'h00, 32'h0,        1'b1,1'b1,1'b1,10'h050, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,32'h0, 1'b0);
    add(1'b1,10'h051, 1'b1,10'h041,32'h22222222,4'b1100, 1'b0,7'h00, 32'h0000AAAA, 1'b1,1'b1,1'b1,10'h051, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b1,32'h0000AAAA, 1'b0);
    add(1'b1,10'h100, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'h0000BBBB, 1'b0,1'b1,1'b0,10'h051, 1'b1,1'b1,1'b0,10'h040,32'h11111111,4'b1111, 1'b0,1'b0,1'b1,32'h0000BBBB, 1'b0);
    add(1'b1,10'h100, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'h0,        1'b1,1'b1,1'b1,10'h100, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,32'h0, 1'b0);
    add(1'b1,10'h100, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'h0000CCCC, 1'b1,1'b1,1'b1,10'h100, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b1,32'h0000CCCC, 1'b0);
    add(1'b0,10'h000, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'h0000DDDD, 1'b1,1'b1,1'b0,10'h100, 1'b1,1'b1,1'b0,10'h041,32'h22222222,4'b1100, 1'b0,1'b0,1'b1,32'h0000DDDD, 1'b0);
    add(1'b0,10'h000, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'h0,        1'b1,1'b1,1'b0,10'h100, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,32'h0, 1'b0);
    // two buffered stores, then refill of line 0x05
    add(1'b1,10'h070, 1'b1,10'h060,32'h33333333,4'b0001, 1'b0,7'h00, 32'h0,        1'b1,1'b1,1'b1,10'h070, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,32'h0, 1'b0);
    add(1'b1,10'h071, 1'b1,10'h061,32'h44444444,4'b1000, 1'b0,7'h00, 32'h0000EEEE, 1'b1,1'b1,1'b1,10'h071, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b1,32'h0000EEEE, 1'b0);
    add(1'b1,10'h072, 1'b1,10'h062,32'h55555555,4'b1111, 1'b1,7'h05, 32'h0000FFFF, 1'b0,1'b0,1'b0,10'h071, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b1,32'h0000FFFF, 1'b0);
    add(1'b1,10'h072, 1'b1,10'h062,32'h55555555,4'b1111, 1'b1,7'h05, 32'h0,        1'b0,1'b0,1'b0,10'h071, 1'b1,1'b1,1'b0,10'h060,32'h33333333,4'b0001, 1'b0,1'b1,1'b0,32'h0, 1'b0);
    add(1'b1,10'h072, 1'b1,10'h062,32'h55555555,4'b1111, 1'b1,7'h05, 32'h0,        1'b0,1'b0,1'b0,10'h071, 1'b1,1'b1,1'b0,10'h061,32'h44444444,4'b1000, 1'b0,1'b1,1'b0,32'h0, 1'b0);
    add(1'b1,10'h072, 1'b1,10'h062,32'h55555555,4'b1111, 1'b1,7'h05, 32'h0,        1'b0,1'b0,1'b0,10'h071, 1'b1,1'b0,1'b1,10'h028,32'h0,4'h0, 1'b1,1'b1,1'b0,32'h0, 1'b1);
    add(1'b1,10'h072, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'h0,        1'b1,1'b1,1'b1,10'h072, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,32'h0, 1'b0);
    add(1'b0,10'h000, 1'b0,10'h000,32'h0,4'h0, 1'b0,7'h00, 32'h0BADCAFE, 1'b1,1'b1,1'b0,10'h072, 1'b0,1'b0,1'b0,10'h000,32'h0,4'h0, 1'b0,1'b0,1'b1,32'h0BADCAFE, 1'b0);

    // Reset state and the initial clear walk
    #3;
    check("reset_zero", {127'h0, any_output()}, 128'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_resetn = 1'b1;
    #2;
    check_clear_walk("clear_init");
    step();

    // Table-driven vectors, one per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      ld_valid = vecs[i].ld_valid; ld_addr = vecs[i].ld_addr;
      st_valid = vecs[i].st_valid; st_addr = vecs[i].st_addr;
      st_data = vecs[i].st_data; st_ben = vecs[i].st_ben;
      rf_valid = vecs[i].rf_valid; rf_line = vecs[i].rf_line; bram_dout = vecs[i].dout;
      #1;
      act = {31'h0, ld_ready, st_ready, bram_re, bram_raddr, bram_we, bram_store, bram_hit_write,
             bram_waddr, bram_din, bram_byte_ben, rf_done, busy, ld_rvalid, ld_rdata};
      exp = {31'h0, vecs[i].e_ldr, vecs[i].e_str, vecs[i].e_re, vecs[i].e_raddr, vecs[i].e_we,
             vecs[i].e_store, vecs[i].e_hw, vecs[i].e_waddr, vecs[i].e_din, vecs[i].e_ben,
             vecs[i].e_rfd, vecs[i].e_busy, vecs[i].e_rv, vecs[i].e_rd};
      check($sformatf("vec%0d_ctl", i), act, exp);
      check_wide($sformatf("vec%0d_line", i), bram_din_all, vecs[i].e_line ? RF_PATTERN : 256'h0);
      step();
    end

    // Reset asserted while draining ahead of a refill with one entry buffered
    idle_inputs();
    ld_valid = 1'b1; ld_addr = 10'h090;
    st_valid = 1'b1; st_addr = 10'h080; st_data = 32'h66666666; st_ben = 4'b1111;
    step();
    idle_inputs();
    rf_valid = 1'b1; rf_line = 7'h03;
    step();
    #1;
    check("mid_drain", {116'h0, bram_we, bram_store, bram_waddr, busy}, {116'h0, 1'b1, 1'b1, 10'h080, 1'b1});
    i_resetn = 1'b0;
    #1;
    check("reset_mid_drain_zero", {127'h0, any_output()}, 128'h0);
    rf_valid = 1'b0; rf_line = 7'h00;
    @(negedge i_clk);
    @(negedge i_clk);
    i_resetn = 1'b1;
    #2;
    check_clear_walk("clear_again");
    ld_valid = 1'b1; ld_addr = 10'h080;
    #1;
    check("post_reset_load", {124'h0, ld_ready, bram_re, bram_we, busy}, {124'h0, 4'b1100});
    step();
    idle_inputs();
    #1;
    check("no_stale_drain", {125'h0, ld_rvalid, bram_we, bram_store}, {125'h0, 3'b100});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
